// File: rtl/graphics_command_decoder.sv
// Graphics command decoder: frames opcode/operand byte streams into palette writes,
// clipped horizontal pixel runs into the frame buffer, and buffer-swap requests.
module graphics_command_decoder #(
    parameter int unsigned DISPLAY_WIDTH  = 640,
    parameter int unsigned DISPLAY_HEIGHT = 400,
    parameter int unsigned INDEX_WIDTH    = 4,
    parameter int unsigned Y_WIDTH        = 4,
    parameter int unsigned CB_WIDTH       = 3,
    parameter int unsigned CR_WIDTH       = 3,
    parameter int unsigned ADDR_WIDTH     = 18
) (
    input  logic                                  clock_in,
    input  logic                                  reset_n_in,
    input  logic [7:0]                            op_code_in,
    input  logic                                  op_code_valid_in,
    input  logic [7:0]                            operand_in,
    input  logic                                  operand_valid_in,
    input  logic [31:0]                           operand_count_in,
    output logic                                  assign_color_enable_out,
    output logic [INDEX_WIDTH-1:0]                assign_color_index_out,
    output logic [Y_WIDTH+CB_WIDTH+CR_WIDTH-1:0]  assign_color_value_out,
    output logic                                  pixel_write_valid_out,
    input  logic                                  pixel_write_ready_in,
    output logic [ADDR_WIDTH-1:0]                 pixel_write_address_out,
    output logic [INDEX_WIDTH-1:0]                pixel_write_data_out,
    output logic                                  switch_buffer_out,
    output logic                                  busy_out,
    output logic                                  error_out
);

    localparam int unsigned VAL_WIDTH = Y_WIDTH + CB_WIDTH + CR_WIDTH;

    localparam logic [1:0] ST_IDLE           = 2'd0;
    localparam logic [1:0] ST_COLLECT        = 2'd1;
    localparam logic [1:0] ST_DRAW           = 2'd2;
    localparam logic [1:0] ST_SWITCH_PENDING = 2'd3;

    localparam logic [7:0] OP_COLOR = 8'h10;
    localparam logic [7:0] OP_RUN   = 8'h12;
    localparam logic [7:0] OP_SHOW  = 8'h17;

    logic [1:0]            state_q, state_d;
    logic                  opv_q, opv_d;
    logic [7:0]            opcode_q, opcode_d;
    logic                  done_q, done_d;
    logic [5:0][7:0]       opb_q, opb_d;
    logic                  pend_q, pend_d;
    logic [15:0]           x_q, x_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INDEX_WIDTH-1:0] color_q, color_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  cen_q, cen_d;
    logic [INDEX_WIDTH-1:0] cidx_q, cidx_d;
    logic [VAL_WIDTH-1:0]  cval_q, cval_d;
    logic                  sw_q, sw_d;
    logic                  err_q, err_d;

    logic        start_c;
    logic        show_c;
    logic        beat_c;
    logic        run_last_c;
    logic [15:0] run_x_c;
    logic [15:0] run_y_c;
    logic [15:0] run_len_c;

    // opv_q resets high so a command already framed at reset release is never seen as new
    assign start_c    = op_code_valid_in && !opv_q;
    assign show_c     = start_c && (op_code_in == OP_SHOW);
    assign beat_c     = valid_q && pixel_write_ready_in;
    assign run_last_c = (len_q == 16'd1) || ((32'(x_q) + 32'd1) >= DISPLAY_WIDTH);
    assign run_x_c    = {opb_q[0], opb_q[1]};
    assign run_y_c    = {opb_q[2], opb_q[3]};
    assign run_len_c  = {opb_q[4], opb_q[5]};

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        opv_d    = op_code_valid_in;
        opcode_d = opcode_q;
        done_d   = done_q;
        opb_d    = opb_q;
        pend_d   = pend_q;
        x_d      = x_q;
        len_d    = len_q;
        addr_d   = addr_q;
        color_d  = color_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        cen_d    = 1'b0;
        cidx_d   = cidx_q;
        cval_d   = cval_q;
        sw_d     = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_SWITCH_PENDING: begin
                state_d = ST_IDLE;
                if (start_c) begin
                    state_d  = ST_COLLECT;
                    opcode_d = op_code_in;
                    // only commands with operands can be left incomplete
                    done_d   = !((op_code_in == OP_COLOR) || (op_code_in == OP_RUN));
                    sw_d     = show_c;
                end
            end

            ST_COLLECT: begin
                if (!op_code_valid_in) begin
                    state_d = ST_IDLE;
                    err_d   = !done_q;
                end else if (operand_valid_in && !done_q) begin
                    for (int i = 0; i < 6; i++) begin
                        if (operand_count_in == 32'(i + 1)) begin
                            opb_d[i] = operand_in;
                        end
                    end
                    if ((opcode_q == OP_COLOR) && (operand_count_in == 32'd4)) begin
                        done_d = 1'b1;
                        cen_d  = 1'b1;
                        cidx_d = opb_q[0][INDEX_WIDTH-1:0];
                        cval_d = {opb_q[1][7 -: Y_WIDTH], opb_q[2][7 -: CB_WIDTH],
                                  operand_in[7 -: CR_WIDTH]};
                    end
                    if ((opcode_q == OP_RUN) && (operand_count_in == 32'd7)) begin
                        done_d = 1'b1;
                        if ((32'(run_x_c) >= DISPLAY_WIDTH) || (32'(run_y_c) >= DISPLAY_HEIGHT)) begin
                            err_d = 1'b1;
                        end else if (run_len_c != 16'd0) begin
                            state_d = ST_DRAW;
                            x_d     = run_x_c;
                            len_d   = run_len_c;
                            addr_d  = ADDR_WIDTH'(32'(run_y_c) * DISPLAY_WIDTH + 32'(run_x_c));
                            color_d = operand_in[INDEX_WIDTH-1:0];
                            valid_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
            end

            ST_DRAW: begin
                if (start_c) begin
                    if (show_c) begin
                        pend_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (beat_c) begin
                    if (run_last_c) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        if (pend_q || show_c) begin
                            state_d = ST_SWITCH_PENDING;
                            sw_d    = 1'b1;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        x_d    = x_q + 16'd1;
                        len_d  = len_q - 16'd1;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= ST_IDLE;
            opv_q    <= 1'b1;
            opcode_q <= 8'h00;
            done_q   <= 1'b1;
            opb_q    <= '0;
            pend_q   <= 1'b0;
            x_q      <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            color_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cen_q    <= 1'b0;
            cidx_q   <= '0;
            cval_q   <= '0;
            sw_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opv_q    <= opv_d;
            opcode_q <= opcode_d;
            done_q   <= done_d;
            opb_q    <= opb_d;
            pend_q   <= pend_d;
            x_q      <= x_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            color_q  <= color_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            cen_q    <= cen_d;
            cidx_q   <= cidx_d;
            cval_q   <= cval_d;
            sw_q     <= sw_d;
            err_q    <= err_d;
        end
    end

    assign assign_color_enable_out = cen_q;
    assign assign_color_index_out  = cidx_q;
    assign assign_color_value_out  = cval_q;
    assign pixel_write_valid_out   = valid_q;
    assign pixel_write_address_out = addr_q;
    assign pixel_write_data_out    = color_q;
    assign switch_buffer_out       = sw_q;
    assign busy_out                = busy_q;
    assign error_out               = err_q;

endmodule

// File: doc/graphics_command_decoder.md
GRAPHICS_COMMAND_DECODER -- requirements
Module: graphics_command_decoder

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, default 640, meaning pixels per line.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, default 400, meaning lines per frame.
REQ-003 SHALL have parameter INDEX_WIDTH, default 4, meaning colour-index bits (palette depth 2^INDEX_WIDTH).
REQ-004 SHALL have parameters Y_WIDTH, CB_WIDTH, CR_WIDTH, defaults 4, 3, 3, meaning YCbCr field widths in a palette value.
REQ-005 SHALL have parameter ADDR_WIDTH, default 18, meaning frame-buffer pixel address bits.
REQ-006 SHALL have ports: clock_in  in  1  system clock; reset_n_in  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: op_code_in  in  8  command opcode; op_code_valid_in  in  1  command framing, high for whole command.
REQ-008 SHALL have ports: operand_in  in  8  operand byte; operand_valid_in  in  1  operand strobe; operand_count_in  in  32  1-based operand number.
REQ-009 SHALL have ports: assign_color_enable_out  out  1  palette write pulse; assign_color_index_out  out  INDEX_WIDTH; assign_color_value_out  out  Y_WIDTH+CB_WIDTH+CR_WIDTH.
REQ-010 SHALL have ports: pixel_write_valid_out  out  1; pixel_write_ready_in  in  1; pixel_write_address_out  out  ADDR_WIDTH; pixel_write_data_out  out  INDEX_WIDTH.
REQ-011 SHALL have ports: switch_buffer_out  out  1  buffer-swap pulse; busy_out  out  1  run draw in progress; error_out  out  1  error pulse.

Function
REQ-012 SHALL start a command on rising op_code_valid_in; command ends on falling op_code_valid_in; each command executes at most once.
REQ-013 SHALL decode 0x10 assign colour: op1 index (low INDEX_WIDTH bits), op2[7:8-Y_WIDTH] -> Y, op3[7:8-CB_WIDTH] -> Cb, op4[7:8-CR_WIDTH] -> Cr; value packed {Y,Cb,Cr}.
REQ-014 SHALL pulse assign_color_enable_out for exactly one cycle, the cycle after op4 strobe, with index/value stable during the pulse; index/value hold their last values otherwise.
REQ-015 SHALL decode 0x12 draw run: op1/op2 x hi/lo, op3/op4 y hi/lo, op5/op6 length hi/lo, op7 colour index; draw starts the cycle after op7 strobe.
REQ-016 SHALL implement FSM states IDLE, COLLECT, DRAW, SWITCH_PENDING; IDLE->COLLECT on command start, COLLECT->DRAW on op7 of 0x12, COLLECT->IDLE on command end, DRAW->SWITCH_PENDING or IDLE on run completion.
REQ-017 SHALL, in DRAW, present address = y*DISPLAY_WIDTH + x and colour index, holding valid/address/data stable until ready; after each accepted beat (valid&&ready) increment address and x, decrement remaining length.
REQ-018 SHALL end the run when remaining length reaches 0 or x reaches DISPLAY_WIDTH (clip, no wrap to next line); busy_out high exactly while in DRAW.
REQ-019 SHALL, for length 0, perform no writes and not enter DRAW; for x>=DISPLAY_WIDTH or y>=DISPLAY_HEIGHT, perform no writes and pulse error_out.
REQ-020 SHALL decode 0x17 buffer show: pulse switch_buffer_out one cycle, the cycle after command start, once per command regardless of command length.
REQ-021 SHALL, for 0x17 arriving during DRAW, record one pending swap and pulse switch_buffer_out the cycle after the last accepted beat; further 0x17 while pending merge into it.
REQ-022 SHALL, for any non-0x17 command started during DRAW, ignore it and pulse error_out once.
REQ-023 SHALL ignore operands with operand_valid_in low, operand counts beyond the command length, and unknown opcodes (no error).
REQ-024 SHALL, when 0x10 or 0x12 ends before its last operand, discard it with no output effect and pulse error_out once.
REQ-025 SHALL pulse outputs (enable, switch, error) only one cycle each; simultaneous events each produce their own pulse in the same cycle.

Reset
REQ-026 SHALL, while reset_n_in low, force all outputs to 0, FSM to IDLE, pending swap cleared; reset mid-DRAW abandons the run with no further beats.
REQ-027 SHALL ignore any command in progress at reset release until op_code_valid_in next rises.

Verification
REQ-028 0x10 ops 0x03,0xA0,0x60,0xE0 -> one enable pulse, index 3, value 10'b1010_011_111.
REQ-029 0x12 x=10,y=2,len=4,colour 5, ready always 1 -> addresses 1290..1293, data 5, busy 4 cycles.
REQ-030 0x12 x=638,y=0,len=5, ready toggling 1/0 -> exactly 2 beats (638,639), each held while ready low.
REQ-031 0x17 during 0x12 run of 8 beats -> switch_buffer_out pulses once, cycle after 8th beat.
REQ-032 0x10 aborted after op2 -> no enable pulse, one error_out pulse; 0x12 with y=400 -> no beats, one error pulse.
REQ-033 reset_n_in low after 3rd beat of 10-beat run -> valid drops asynchronously, no further beats after release.
